id_stage: RTL and testbench
===========================

# id_stage

Instruction-decode stage of the 5-stage RV32I pipeline. It sits between the IF/ID register and the EX unit and drives the register-file read addresses. It registers operands, the immediate and control fields into the ID/EX pipeline register. It also owns the load-use interlock, EX back-pressure hold and branch flush for the front end.

## Interface
- No parameters; XLEN fixed at 32.
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, synchronous, active-high.
- inst_i  in  32  instruction from IF/ID.
- inst_addr_i  in  32  PC of inst_i.
- inst_valid_i  in  1  inst_i is a real instruction (0 = bubble).
- stall_o  out  1  combinational; hold PC and IF/ID this cycle.
- flush_i  in  1  branch/jump taken in EX; squash the ID instruction.
- ex_ready_i  in  1  EX accepts a new instruction this cycle.
- rs1_addr_o, rs2_addr_o  out  5  register-file read addresses; combinational, always inst_i[19:15], inst_i[24:20].
- rs1_data_i, rs2_data_i  in  32  register-file read data; already bypassed for same-cycle WB writes.
- ex_valid_o  out  1  ID/EX holds a valid instruction.
- ex_inst_addr_o  out  32  PC.
- ex_op_a_o, ex_op_b_o  out  32  rs1 and rs2 data.
- ex_imm_o  out  32  sign-extended immediate.
- ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o  out  5  used by EX forwarding.
- ex_rd_wen_o  out  1  instruction writes rd; forced 0 when rd = x0.
- ex_opcode_o  out  7, ex_funct3_o  out  3, ex_funct7b5_o  out  1  raw control fields.
- ex_mem_rd_o, ex_mem_wr_o  out  1  load and store.
- ex_illegal_o  out  1  opcode not in RV32I base set.
- bubble_cnt_o  out  32  count of load-use bubbles inserted; wraps at 2^32.

## Operation
- Decode is purely combinational on inst_i. The ID/EX register captures its result.
- Immediate formats:
  - I: LOAD, OP-IMM, JALR.
  - S: STORE.
  - B: BRANCH.
  - U: LUI, AUIPC.
  - J: JAL.
  - Other opcodes: imm = 0.
  - All formats sign-extend from inst_i[31].
- rs1 is used by every opcode except LUI, AUIPC and JAL. rs2 is used by OP, STORE and BRANCH.
- Load-use hazard is asserted when all of the following hold:
  - ex_valid_o and ex_mem_rd_o are set;
  - ex_rd_addr_o is not 0;
  - inst_valid_i is set;
  - ex_rd_addr_o equals a source register that the ID instruction uses.
- Per-cycle action, in priority order:
  1. rst: clear all ID/EX fields and bubble_cnt_o.
  2. flush_i: ex_valid_o ← 0, other fields don't-care; stall_o = 0 (IF redirects).
  3. !ex_ready_i: ID/EX holds its contents; stall_o = 1.
  4. load-use hazard: insert a bubble (ex_valid_o ← 0, ex_rd_wen_o ← 0, ex_mem_rd_o ← 0, ex_mem_wr_o ← 0); stall_o = 1; bubble_cnt_o += 1.
  5. Otherwise, capture the decode result; ex_valid_o ← inst_valid_i; stall_o = 0.
- When ex_valid_o = 0, ex_rd_wen_o, ex_mem_rd_o, ex_mem_wr_o and ex_illegal_o are all 0.
- Forwarding from EX/MEM and MEM/WB is done by the EX unit, not by this block.

## Timing
- Latency: 1 cycle, inst_i → ex_* outputs.
- Reset value of every ex_* output and of bubble_cnt_o is 0. stall_o = 0 while rst is high.
- A load-use stall lasts exactly 1 cycle. The next cycle the load sits in MEM, the hazard term is false, and the dependent instruction issues.
- Back-pressure lasting N cycles gives N cycles of stall_o with the ID/EX register unchanged. Any hazard is re-evaluated after release.
- flush_i coincident with a hazard or with !ex_ready_i: the flush wins and bubble_cnt_o does not increment.
- Reset asserted mid-stall: the ID/EX register clears on the next edge and stall_o drops immediately.

## Structure
- Shared package riscv_pkg holds:
  - opcode constants OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP, OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_FENCE;
  - immediate-format enum (IMM_I, IMM_S, IMM_B, IMM_U, IMM_J, IMM_NONE).
- Sub-module imm_gen: combinational, inst[31:0] plus format → imm[31:0].
- The hazard logic and the ID/EX register stay in id_stage.

## Test plan
- Reset: rst held 2 cycles with inst_valid_i = 1 → ex_valid_o = 0, all ex_* = 0, bubble_cnt_o = 0, stall_o = 0.
- ADDI x1,x0,5 (0x00500093) → next cycle ex_valid_o = 1, ex_rd_addr_o = 1, ex_rd_wen_o = 1, ex_imm_o = 0x00000005, stall_o = 0.
- LW x2,0(x1) (0x0000A103) then ADD x3,x2,x1 (0x001101B3):
  - stall_o = 1 for one cycle and a bubble enters EX;
  - ADD issues the following cycle;
  - bubble_cnt_o = 1.
- BEQ x1,x2,-4 (0xFE208EE3) → ex_imm_o = 0xFFFFFFFC, ex_rd_wen_o = 0. A load to x0 followed by a use of x0 → no stall.
- ex_ready_i low for 3 cycles → ID/EX unchanged for 3 cycles, stall_o = 1 for 3 cycles.
- flush_i asserted during a load-use hazard → ex_valid_o = 0 next cycle, stall_o = 0, bubble_cnt_o unchanged.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared RV32I definitions: opcodes, immediate formats and the ID/EX record.
// The decode helpers here are used by the decode stage and the immediate generator.
package riscv_pkg;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;
  localparam logic [6:0] OPC_FENCE  = 7'b0001111;

  typedef enum logic [2:0] {
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J,
    IMM_NONE
  } imm_fmt_e;

  typedef struct packed {
    logic        valid;
    logic [31:0] inst_addr;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] imm;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7b5;
    logic        mem_rd;
    logic        mem_wr;
    logic        illegal;
  } idex_t;

  function automatic imm_fmt_e imm_fmt(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_JALR: imm_fmt = IMM_I;
      OPC_STORE:                      imm_fmt = IMM_S;
      OPC_BRANCH:                     imm_fmt = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_fmt = IMM_U;
      OPC_JAL:                        imm_fmt = IMM_J;
      default:                        imm_fmt = IMM_NONE;
    endcase
  endfunction

  function automatic logic is_legal(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_STORE, OPC_BRANCH, OPC_JAL, OPC_JALR, OPC_OP,
      OPC_OP_IMM, OPC_LUI, OPC_AUIPC, OPC_SYSTEM, OPC_FENCE: is_legal = 1'b1;
      default:                                               is_legal = 1'b0;
    endcase
  endfunction

  // Opcodes whose architectural result lands in rd.
  function automatic logic writes_rd(input logic [6:0] opc);
    case (opc)
      OPC_LOAD, OPC_OP_IMM, OPC_OP, OPC_LUI, OPC_AUIPC,
      OPC_JAL, OPC_JALR: writes_rd = 1'b1;
      default:           writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/id_stage_if.sv
// ID/EX pipeline bus: the registered decode result plus EX back-pressure.
// The decode stage is the master; the EX unit is the slave.
interface id_stage_if;

  logic        ex_ready_i;
  logic        ex_valid_o;
  logic [31:0] ex_inst_addr_o;
  logic [31:0] ex_op_a_o;
  logic [31:0] ex_op_b_o;
  logic [31:0] ex_imm_o;
  logic [4:0]  ex_rs1_addr_o;
  logic [4:0]  ex_rs2_addr_o;
  logic [4:0]  ex_rd_addr_o;
  logic        ex_rd_wen_o;
  logic [6:0]  ex_opcode_o;
  logic [2:0]  ex_funct3_o;
  logic        ex_funct7b5_o;
  logic        ex_mem_rd_o;
  logic        ex_mem_wr_o;
  logic        ex_illegal_o;

  modport master (
    input  ex_ready_i,
    output ex_valid_o, ex_inst_addr_o, ex_op_a_o, ex_op_b_o, ex_imm_o,
           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_rd_wen_o,
           ex_opcode_o, ex_funct3_o, ex_funct7b5_o, ex_mem_rd_o,
           ex_mem_wr_o, ex_illegal_o
  );

  modport slave (
    output ex_ready_i,
    input  ex_valid_o, ex_inst_addr_o, ex_op_a_o, ex_op_b_o, ex_imm_o,
           ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o, ex_rd_wen_o,
           ex_opcode_o, ex_funct3_o, ex_funct7b5_o, ex_mem_rd_o,
           ex_mem_wr_o, ex_illegal_o
  );

endinterface

// File: rtl/imm_gen.sv
// Combinational RV32I immediate generator; every format sign-extends from inst[31].
module imm_gen
  import riscv_pkg::*;
(
  input  logic [31:0] inst,
  input  imm_fmt_e    fmt,
  output logic [31:0] imm
);

  always_comb begin
    imm = 32'd0;
    case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'd0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = 32'd0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV32I instruction-decode stage: decodes inst_i, owns the ID/EX register,
// the load-use interlock, EX back-pressure hold and branch flush.
module id_stage
  import riscv_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       inst_i,
  input  logic [31:0]       inst_addr_i,
  input  logic              inst_valid_i,
  output logic              stall_o,
  input  logic              flush_i,
  output logic [4:0]        rs1_addr_o,
  output logic [4:0]        rs2_addr_o,
  input  logic [31:0]       rs1_data_i,
  input  logic [31:0]       rs2_data_i,
  output logic [31:0]       bubble_cnt_o,
  id_stage_if.master        ex
);

  logic [6:0]  opcode;
  logic [4:0]  rd_addr;
  logic [31:0] imm;
  logic        uses_rs1;
  logic        uses_rs2;
  logic        hazard;
  idex_t       dec;
  idex_t       idex_q;
  logic [31:0] bubble_cnt_q;

  assign opcode     = inst_i[6:0];
  assign rd_addr    = inst_i[11:7];
  assign rs1_addr_o = inst_i[19:15];
  assign rs2_addr_o = inst_i[24:20];

  imm_gen u_imm_gen (
    .inst (inst_i),
    .fmt  (imm_fmt(opcode)),
    .imm  (imm)
  );

  assign uses_rs1 = (opcode != OPC_LUI) && (opcode != OPC_AUIPC) && (opcode != OPC_JAL);
  assign uses_rs2 = (opcode == OPC_OP) || (opcode == OPC_STORE) || (opcode == OPC_BRANCH);

  // Control bits are gated by inst_valid_i so a bubble from IF never carries side effects.
  always_comb begin
    dec           = '0;
    dec.valid     = inst_valid_i;
    dec.inst_addr = inst_addr_i;
    dec.op_a      = rs1_data_i;
    dec.op_b      = rs2_data_i;
    dec.imm       = imm;
    dec.rs1_addr  = rs1_addr_o;
    dec.rs2_addr  = rs2_addr_o;
    dec.rd_addr   = rd_addr;
    dec.opcode    = opcode;
    dec.funct3    = inst_i[14:12];
    dec.funct7b5  = inst_i[30];
    dec.rd_wen    = inst_valid_i && writes_rd(opcode) && (rd_addr != 5'd0);
    dec.mem_rd    = inst_valid_i && (opcode == OPC_LOAD);
    dec.mem_wr    = inst_valid_i && (opcode == OPC_STORE);
    dec.illegal   = inst_valid_i && !is_legal(opcode);
  end

  assign hazard = idex_q.valid && idex_q.mem_rd && (idex_q.rd_addr != 5'd0) && inst_valid_i &&
                  ((uses_rs1 && (idex_q.rd_addr == rs1_addr_o)) ||
                   (uses_rs2 && (idex_q.rd_addr == rs2_addr_o)));

  // Flush takes precedence so IF can redirect immediately.
  assign stall_o = !rst && !flush_i && (!ex.ex_ready_i || hazard);

  always_ff @(posedge clk) begin
    if (rst) begin
      idex_q       <= '0;
      bubble_cnt_q <= 32'd0;
    end else if (flush_i) begin
      idex_q.valid   <= 1'b0;
      idex_q.rd_wen  <= 1'b0;
      idex_q.mem_rd  <= 1'b0;
      idex_q.mem_wr  <= 1'b0;
      idex_q.illegal <= 1'b0;
    end else if (!ex.ex_ready_i) begin
      idex_q <= idex_q;
    end else if (hazard) begin
      idex_q.valid   <= 1'b0;
      idex_q.rd_wen  <= 1'b0;
      idex_q.mem_rd  <= 1'b0;
      idex_q.mem_wr  <= 1'b0;
      idex_q.illegal <= 1'b0;
      bubble_cnt_q   <= bubble_cnt_q + 32'd1;
    end else begin
      idex_q <= dec;
    end
  end

  assign bubble_cnt_o      = bubble_cnt_q;
  assign ex.ex_valid_o     = idex_q.valid;
  assign ex.ex_inst_addr_o = idex_q.inst_addr;
  assign ex.ex_op_a_o      = idex_q.op_a;
  assign ex.ex_op_b_o      = idex_q.op_b;
  assign ex.ex_imm_o       = idex_q.imm;
  assign ex.ex_rs1_addr_o  = idex_q.rs1_addr;
  assign ex.ex_rs2_addr_o  = idex_q.rs2_addr;
  assign ex.ex_rd_addr_o   = idex_q.rd_addr;
  assign ex.ex_rd_wen_o    = idex_q.rd_wen;
  assign ex.ex_opcode_o    = idex_q.opcode;
  assign ex.ex_funct3_o    = idex_q.funct3;
  assign ex.ex_funct7b5_o  = idex_q.funct7b5;
  assign ex.ex_mem_rd_o    = idex_q.mem_rd;
  assign ex.ex_mem_wr_o    = idex_q.mem_wr;
  assign ex.ex_illegal_o   = idex_q.illegal;

endmodule

// File: tb/tb_id_stage.sv
// Directed testbench for id_stage: hand-decoded RV32I vectors with expected
// ID/EX contents, interlock, back-pressure, flush and reset behaviour.
module tb_id_stage;

  logic        clk;
  logic        rst;
  logic [31:0] inst_i;
  logic [31:0] inst_addr_i;
  logic        inst_valid_i;
  logic        stall_o;
  logic        flush_i;
  logic [4:0]  rs1_addr_o;
  logic [4:0]  rs2_addr_o;
  logic [31:0] rs1_data_i;
  logic [31:0] rs2_data_i;
  logic [31:0] bubble_cnt_o;

  int n_cmp = 0;
  int n_err = 0;

  id_stage_if ex_if ();

  id_stage dut (
    .clk          (clk),
    .rst          (rst),
    .inst_i       (inst_i),
    .inst_addr_i  (inst_addr_i),
    .inst_valid_i (inst_valid_i),
    .stall_o      (stall_o),
    .flush_i      (flush_i),
    .rs1_addr_o   (rs1_addr_o),
    .rs2_addr_o   (rs2_addr_o),
    .rs1_data_i   (rs1_data_i),
    .rs2_data_i   (rs2_data_i),
    .bubble_cnt_o (bubble_cnt_o),
    .ex           (ex_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [31:0] I_ADDI_X1_5  = 32'h00500093;
  localparam logic [31:0] I_LW_X2_X1   = 32'h0000A103;
  localparam logic [31:0] I_ADD_X3     = 32'h001101B3;
  localparam logic [31:0] I_BEQ_M4     = 32'hFE208EE3;
  localparam logic [31:0] I_LW_X0_X1   = 32'h0000A003;
  localparam logic [31:0] I_ADD_X3_X0  = 32'h000001B3;
  localparam logic [31:0] I_LUI_X5     = 32'h123452B7;
  localparam logic [31:0] I_JAL_X1_8   = 32'h008000EF;
  localparam logic [31:0] I_SW_X2_4    = 32'h0020A223;

  task automatic drive(input logic [31:0] inst, input logic [31:0] pc, input logic valid);
    inst_i       = inst;
    inst_addr_i  = pc;
    inst_valid_i = valid;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    flush_i = 1'b0;
    ex_if.ex_ready_i = 1'b1;
    rs1_data_i = 32'h0;
    rs2_data_i = 32'h0;
    drive(I_ADDI_X1_5, 32'h0000_0100, 1'b1);
    step();
    step();
    n_cmp++; if (ex_if.ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_valid got %h want 0", ex_if.ex_valid_o); end
    n_cmp++; if (ex_if.ex_rd_addr_o !== 5'd0) begin n_err++; $display("[TB] FAIL reset_rd got %h want 0", ex_if.ex_rd_addr_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_wen got %h want 0", ex_if.ex_rd_wen_o); end
    n_cmp++; if (ex_if.ex_imm_o !== 32'd0) begin n_err++; $display("[TB] FAIL reset_imm got %h want 0", ex_if.ex_imm_o); end
    n_cmp++; if (ex_if.ex_inst_addr_o !== 32'd0) begin n_err++; $display("[TB] FAIL reset_pc got %h want 0", ex_if.ex_inst_addr_o); end
    n_cmp++; if (ex_if.ex_opcode_o !== 7'd0) begin n_err++; $display("[TB] FAIL reset_opcode got %h want 0", ex_if.ex_opcode_o); end
    n_cmp++; if (bubble_cnt_o !== 32'd0) begin n_err++; $display("[TB] FAIL reset_bubbles got %h want 0", bubble_cnt_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL reset_stall got %h want 0", stall_o); end
    rst = 1'b0;
  endtask

  task automatic test_addi();
    drive(I_ADDI_X1_5, 32'h0000_0100, 1'b1);
    #1;
    n_cmp++; if (rs1_addr_o !== 5'd0) begin n_err++; $display("[TB] FAIL addi_rs1_addr got %h want 0", rs1_addr_o); end
    n_cmp++; if (rs2_addr_o !== 5'd5) begin n_err++; $display("[TB] FAIL addi_rs2_addr got %h want 5", rs2_addr_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL addi_stall got %h want 0", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL addi_valid got %h want 1", ex_if.ex_valid_o); end
    n_cmp++; if (ex_if.ex_rd_addr_o !== 5'd1) begin n_err++; $display("[TB] FAIL addi_rd got %h want 1", ex_if.ex_rd_addr_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b1) begin n_err++; $display("[TB] FAIL addi_wen got %h want 1", ex_if.ex_rd_wen_o); end
    n_cmp++; if (ex_if.ex_imm_o !== 32'h0000_0005) begin n_err++; $display("[TB] FAIL addi_imm got %h want 00000005", ex_if.ex_imm_o); end
    n_cmp++; if (ex_if.ex_inst_addr_o !== 32'h0000_0100) begin n_err++; $display("[TB] FAIL addi_pc got %h want 00000100", ex_if.ex_inst_addr_o); end
    n_cmp++; if (ex_if.ex_opcode_o !== 7'h13) begin n_err++; $display("[TB] FAIL addi_opcode got %h want 13", ex_if.ex_opcode_o); end
    n_cmp++; if (ex_if.ex_illegal_o !== 1'b0) begin n_err++; $display("[TB] FAIL addi_illegal got %h want 0", ex_if.ex_illegal_o); end
  endtask

  task automatic test_load_use();
    drive(I_LW_X2_X1, 32'h0000_0104, 1'b1);
    step();
    n_cmp++; if (ex_if.ex_mem_rd_o !== 1'b1) begin n_err++; $display("[TB] FAIL lw_mem_rd got %h want 1", ex_if.ex_mem_rd_o); end
    n_cmp++; if (ex_if.ex_rd_addr_o !== 5'd2) begin n_err++; $display("[TB] FAIL lw_rd got %h want 2", ex_if.ex_rd_addr_o); end
    drive(I_ADD_X3, 32'h0000_0108, 1'b1);
    rs1_data_i = 32'h0000_AAAA;
    rs2_data_i = 32'h0000_5555;
    #1;
    n_cmp++; if (rs1_addr_o !== 5'd2) begin n_err++; $display("[TB] FAIL add_rs1_addr got %h want 2", rs1_addr_o); end
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL loaduse_stall got %h want 1", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL bubble_valid got %h want 0", ex_if.ex_valid_o); end
    n_cmp++; if (ex_if.ex_mem_rd_o !== 1'b0) begin n_err++; $display("[TB] FAIL bubble_mem_rd got %h want 0", ex_if.ex_mem_rd_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b0) begin n_err++; $display("[TB] FAIL bubble_wen got %h want 0", ex_if.ex_rd_wen_o); end
    n_cmp++; if (bubble_cnt_o !== 32'd1) begin n_err++; $display("[TB] FAIL bubble_cnt got %h want 1", bubble_cnt_o); end
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL loaduse_release got %h want 0", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL add_valid got %h want 1", ex_if.ex_valid_o); end
    n_cmp++; if (ex_if.ex_rd_addr_o !== 5'd3) begin n_err++; $display("[TB] FAIL add_rd got %h want 3", ex_if.ex_rd_addr_o); end
    n_cmp++; if (ex_if.ex_op_a_o !== 32'h0000_AAAA) begin n_err++; $display("[TB] FAIL add_op_a got %h want 0000aaaa", ex_if.ex_op_a_o); end
    n_cmp++; if (ex_if.ex_op_b_o !== 32'h0000_5555) begin n_err++; $display("[TB] FAIL add_op_b got %h want 00005555", ex_if.ex_op_b_o); end
    n_cmp++; if (ex_if.ex_opcode_o !== 7'h33) begin n_err++; $display("[TB] FAIL add_opcode got %h want 33", ex_if.ex_opcode_o); end
    n_cmp++; if (ex_if.ex_inst_addr_o !== 32'h0000_0108) begin n_err++; $display("[TB] FAIL add_pc got %h want 00000108", ex_if.ex_inst_addr_o); end
    n_cmp++; if (bubble_cnt_o !== 32'd1) begin n_err++; $display("[TB] FAIL add_bubble_cnt got %h want 1", bubble_cnt_o); end
  endtask

  task automatic test_branch();
    drive(I_BEQ_M4, 32'h0000_010C, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL beq_stall got %h want 0", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_imm_o !== 32'hFFFF_FFFC) begin n_err++; $display("[TB] FAIL beq_imm got %h want fffffffc", ex_if.ex_imm_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b0) begin n_err++; $display("[TB] FAIL beq_wen got %h want 0", ex_if.ex_rd_wen_o); end
    n_cmp++; if (ex_if.ex_rs2_addr_o !== 5'd2) begin n_err++; $display("[TB] FAIL beq_rs2 got %h want 2", ex_if.ex_rs2_addr_o); end
    n_cmp++; if (ex_if.ex_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL beq_valid got %h want 1", ex_if.ex_valid_o); end
  endtask

  task automatic test_imm_formats();
    drive(I_LUI_X5, 32'h0000_0110, 1'b1);
    step();
    n_cmp++; if (ex_if.ex_imm_o !== 32'h1234_5000) begin n_err++; $display("[TB] FAIL lui_imm got %h want 12345000", ex_if.ex_imm_o); end
    n_cmp++; if (ex_if.ex_rd_addr_o !== 5'd5) begin n_err++; $display("[TB] FAIL lui_rd got %h want 5", ex_if.ex_rd_addr_o); end
    drive(I_JAL_X1_8, 32'h0000_0114, 1'b1);
    step();
    n_cmp++; if (ex_if.ex_imm_o !== 32'h0000_0008) begin n_err++; $display("[TB] FAIL jal_imm got %h want 00000008", ex_if.ex_imm_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b1) begin n_err++; $display("[TB] FAIL jal_wen got %h want 1", ex_if.ex_rd_wen_o); end
    drive(I_SW_X2_4, 32'h0000_0118, 1'b1);
    step();
    n_cmp++; if (ex_if.ex_imm_o !== 32'h0000_0004) begin n_err++; $display("[TB] FAIL sw_imm got %h want 00000004", ex_if.ex_imm_o); end
    n_cmp++; if (ex_if.ex_mem_wr_o !== 1'b1) begin n_err++; $display("[TB] FAIL sw_mem_wr got %h want 1", ex_if.ex_mem_wr_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b0) begin n_err++; $display("[TB] FAIL sw_wen got %h want 0", ex_if.ex_rd_wen_o); end
  endtask

  task automatic test_x0_load();
    drive(I_LW_X0_X1, 32'h0000_0120, 1'b1);
    step();
    n_cmp++; if (ex_if.ex_mem_rd_o !== 1'b1) begin n_err++; $display("[TB] FAIL lwx0_mem_rd got %h want 1", ex_if.ex_mem_rd_o); end
    n_cmp++; if (ex_if.ex_rd_wen_o !== 1'b0) begin n_err++; $display("[TB] FAIL lwx0_wen got %h want 0", ex_if.ex_rd_wen_o); end
    drive(I_ADD_X3_X0, 32'h0000_0124, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL x0_no_stall got %h want 0", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL x0_add_valid got %h want 1", ex_if.ex_valid_o); end
    n_cmp++; if (bubble_cnt_o !== 32'd1) begin n_err++; $display("[TB] FAIL x0_bubble_cnt got %h want 1", bubble_cnt_o); end
  endtask

  task automatic test_backpressure();
    drive(I_ADDI_X1_5, 32'h0000_0200, 1'b1);
    ex_if.ex_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL bp_stall[%0d] got %h want 1", i, stall_o); end
      step();
      n_cmp++; if (ex_if.ex_inst_addr_o !== 32'h0000_0124) begin n_err++; $display("[TB] FAIL bp_hold_pc[%0d] got %h want 00000124", i, ex_if.ex_inst_addr_o); end
      n_cmp++; if (ex_if.ex_rd_addr_o !== 5'd3) begin n_err++; $display("[TB] FAIL bp_hold_rd[%0d] got %h want 3", i, ex_if.ex_rd_addr_o); end
    end
    ex_if.ex_ready_i = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL bp_release got %h want 0", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_inst_addr_o !== 32'h0000_0200) begin n_err++; $display("[TB] FAIL bp_issue_pc got %h want 00000200", ex_if.ex_inst_addr_o); end
  endtask

  task automatic test_flush();
    drive(I_LW_X2_X1, 32'h0000_0300, 1'b1);
    step();
    drive(I_ADD_X3, 32'h0000_0304, 1'b1);
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL flush_pre_stall got %h want 1", stall_o); end
    flush_i = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_stall got %h want 0", stall_o); end
    step();
    flush_i = 1'b0;
    n_cmp++; if (ex_if.ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_valid got %h want 0", ex_if.ex_valid_o); end
    n_cmp++; if (ex_if.ex_mem_rd_o !== 1'b0) begin n_err++; $display("[TB] FAIL flush_mem_rd got %h want 0", ex_if.ex_mem_rd_o); end
    n_cmp++; if (bubble_cnt_o !== 32'd1) begin n_err++; $display("[TB] FAIL flush_bubble_cnt got %h want 1", bubble_cnt_o); end
  endtask

  task automatic test_illegal();
    drive(32'h0000_0000, 32'h0000_0400, 1'b1);
    step();
    n_cmp++; if (ex_if.ex_illegal_o !== 1'b1) begin n_err++; $display("[TB] FAIL illegal_flag got %h want 1", ex_if.ex_illegal_o); end
    n_cmp++; if (ex_if.ex_valid_o !== 1'b1) begin n_err++; $display("[TB] FAIL illegal_valid got %h want 1", ex_if.ex_valid_o); end
    drive(32'h0000_0000, 32'h0000_0404, 1'b0);
    step();
    n_cmp++; if (ex_if.ex_illegal_o !== 1'b0) begin n_err++; $display("[TB] FAIL nop_illegal got %h want 0", ex_if.ex_illegal_o); end
    n_cmp++; if (ex_if.ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL nop_valid got %h want 0", ex_if.ex_valid_o); end
  endtask

  task automatic test_reset_mid_stall();
    drive(I_LW_X2_X1, 32'h0000_0500, 1'b1);
    step();
    drive(I_ADD_X3, 32'h0000_0504, 1'b1);
    ex_if.ex_ready_i = 1'b0;
    #1;
    n_cmp++; if (stall_o !== 1'b1) begin n_err++; $display("[TB] FAIL mid_pre_stall got %h want 1", stall_o); end
    rst = 1'b1;
    #1;
    n_cmp++; if (stall_o !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst_stall got %h want 0", stall_o); end
    step();
    n_cmp++; if (ex_if.ex_valid_o !== 1'b0) begin n_err++; $display("[TB] FAIL mid_rst_valid got %h want 0", ex_if.ex_valid_o); end
    n_cmp++; if (ex_if.ex_inst_addr_o !== 32'd0) begin n_err++; $display("[TB] FAIL mid_rst_pc got %h want 0", ex_if.ex_inst_addr_o); end
    n_cmp++; if (bubble_cnt_o !== 32'd0) begin n_err++; $display("[TB] FAIL mid_rst_bubbles got %h want 0", bubble_cnt_o); end
    rst = 1'b0;
    ex_if.ex_ready_i = 1'b1;
  endtask

  initial begin
    test_reset();
    test_addi();
    test_load_use();
    test_branch();
    test_imm_formats();
    test_x0_load();
    test_backpressure();
    test_flush();
    test_illegal();
    test_reset_mid_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
